mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 53 +++++
 rtl/config.sv | 8 +
 rtl/mem_arb_req_buf.sv | 27 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the icache/dcache DRAM arbiter.
// ARB_ROUND_ROBIN_EN selects the round-robin grant function.
`ifndef MEM_CONFIG_SV
`include "config.sv"
`endif

package mem_arb_pkg;

    localparam int ADDR_W  = `DRAM_ADDRESS_SIZE;
    localparam int BLOCK_W = `DRAM_WORD_SIZE * `DRAM_BLOCK_SIZE;
    localparam int DREQ_W  = 1 + ADDR_W + BLOCK_W;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic [1:0] {
        ARB_NONE,
        ARB_I,
        ARB_D
    } arb_grant_t;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the requester not served most recently wins.
    function automatic arb_grant_t pick_grant(
        input logic i_pend,
        input logic d_pend,
        input logic last_d
    );
        if (i_pend && d_pend)
            return last_d ? ARB_I : ARB_D;
        else if (d_pend)
            return ARB_D;
        else if (i_pend)
            return ARB_I;
        return ARB_NONE;
    endfunction
`else
    function automatic arb_grant_t pick_grant(
        input logic i_pend,
        input logic d_pend
    );
        if (d_pend)
            return ARB_D;
        else if (i_pend)
            return ARB_I;
        return ARB_NONE;
    endfunction
`endif

endpackage

// File: rtl/config.sv
// DRAM geometry shared by the memory arbiter, its package and its bench.
// Address width, word width and words per block.
`ifndef MEM_CONFIG_SV
`define MEM_CONFIG_SV
`define DRAM_ADDRESS_SIZE 32
`define DRAM_WORD_SIZE 32
`define DRAM_BLOCK_SIZE 4
`endif

// File: rtl/mem_arb_req_buf.sv
// One-deep pending request buffer for a single arbiter client.
// A new request is taken when idle or in the cycle the old one retires.
module mem_arb_req_buf #(
    parameter int W = mem_arb_pkg::ADDR_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid,
    input  logic [W-1:0] req,
    input  logic         clear,
    output logic         pending,
    output logic [W-1:0] held
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            held    <= '0;
        end else if (valid && (!pending || clear)) begin
            pending <= 1'b1;
            held    <= req;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache block requests onto one DRAM port.
// ARB_ROUND_ROBIN_EN: round-robin on ties, otherwise dcache priority.
`ifndef MEM_CONFIG_SV
`include "config.sv"
`endif

module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  ic_mem_address,
    input  logic               ic_mem_valid,
    output logic [BLOCK_W-1:0] ic_mem_data,
    output logic               ic_mem_ready,
    input  logic [ADDR_W-1:0]  dc_mem_address,
    input  logic               dc_mem_valid,
    input  logic               dc_mem_rw,
    input  logic [BLOCK_W-1:0] dc_mem_wdata,
    output logic [BLOCK_W-1:0] dc_mem_data,
    output logic               dc_mem_ready,
    output logic [ADDR_W-1:0]  dram_address,
    output logic               dram_valid,
    output logic               dram_rw,
    output logic [BLOCK_W-1:0] dram_wdata,
    input  logic [BLOCK_W-1:0] dram_rdata,
    input  logic               dram_ready
);

    arb_state_t state;
    arb_state_t state_nxt;
    arb_grant_t grant;
    logic       first;

    logic              i_pend;
    logic              d_pend;
    logic [ADDR_W-1:0] i_addr;
    logic [DREQ_W-1:0] d_held;

    logic               d_rw;
    logic [ADDR_W-1:0]  d_addr;
    logic [BLOCK_W-1:0] d_wdata;

    assign {d_rw, d_addr, d_wdata} = d_held;

    mem_arb_req_buf #(.W(ADDR_W)) u_ibuf (
        .clock   (clock),
        .reset   (reset),
        .valid   (ic_mem_valid),
        .req     (ic_mem_address),
        .clear   (ic_mem_ready),
        .pending (i_pend),
        .held    (i_addr)
    );

    mem_arb_req_buf #(.W(DREQ_W)) u_dbuf (
        .clock   (clock),
        .reset   (reset),
        .valid   (dc_mem_valid),
        .req     ({dc_mem_rw, dc_mem_address, dc_mem_wdata}),
        .clear   (dc_mem_ready),
        .pending (d_pend),
        .held    (d_held)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last_d <= 1'b0;
        else if (state == IDLE && grant != ARB_NONE)
            last_d <= (grant == ARB_D);
    end

    assign grant = pick_grant(i_pend, d_pend, last_d);
`else
    assign grant = pick_grant(i_pend, d_pend);
`endif

    // first marks the single request cycle at the start of a service
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            first <= 1'b0;
        end else begin
            state <= state_nxt;
            first <= (state == IDLE) && (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant == ARB_D)
                    state_nxt = SERVE_D;
                else if (grant == ARB_I)
                    state_nxt = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (dram_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dram_valid   = first;
        dram_address = '0;
        dram_rw      = 1'b0;
        dram_wdata   = '0;
        ic_mem_ready = 1'b0;
        dc_mem_ready = 1'b0;
        unique case (1'b1)
            (state == SERVE_I): begin
                dram_address = i_addr;
                ic_mem_ready = dram_ready;
            end
            (state == SERVE_D): begin
                dram_address = d_addr;
                dram_rw      = d_rw;
                dram_wdata   = d_wdata;
                dc_mem_ready = dram_ready;
            end
            default: ;
        endcase
    end

    assign ic_mem_data = dram_rdata;
    assign dc_mem_data = dram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
`ifndef MEM_CONFIG_SV
`include "config.sv"
`endif

module tb_mem_arbiter;

    localparam int AW = `DRAM_ADDRESS_SIZE;
    localparam int BW = `DRAM_WORD_SIZE * `DRAM_BLOCK_SIZE;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] ic_mem_address;
    logic          ic_mem_valid;
    logic [BW-1:0] ic_mem_data;
    logic          ic_mem_ready;
    logic [AW-1:0] dc_mem_address;
    logic          dc_mem_valid;
    logic          dc_mem_rw;
    logic [BW-1:0] dc_mem_wdata;
    logic [BW-1:0] dc_mem_data;
    logic          dc_mem_ready;
    logic [AW-1:0] dram_address;
    logic          dram_valid;
    logic          dram_rw;
    logic [BW-1:0] dram_wdata;
    logic [BW-1:0] dram_rdata;
    logic          dram_ready;

    int total = 0;
    int bad = 0;
    int dv_cnt = 0;
    int dr_cnt = 0;
    int base_dv;
    int base_dr;
    logic both_seen = 1'b0;

    logic [BW-1:0] p1;
    logic [BW-1:0] p2;
    logic [BW-1:0] wblk;

    mem_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .ic_mem_address (ic_mem_address),
        .ic_mem_valid   (ic_mem_valid),
        .ic_mem_data    (ic_mem_data),
        .ic_mem_ready   (ic_mem_ready),
        .dc_mem_address (dc_mem_address),
        .dc_mem_valid   (dc_mem_valid),
        .dc_mem_rw      (dc_mem_rw),
        .dc_mem_wdata   (dc_mem_wdata),
        .dc_mem_data    (dc_mem_data),
        .dc_mem_ready   (dc_mem_ready),
        .dram_address   (dram_address),
        .dram_valid     (dram_valid),
        .dram_rw        (dram_rw),
        .dram_wdata     (dram_wdata),
        .dram_rdata     (dram_rdata),
        .dram_ready     (dram_ready)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (dram_valid)
            dv_cnt++;
        if (dc_mem_ready)
            dr_cnt++;
        if (ic_mem_ready && dc_mem_ready)
            both_seen = 1'b1;
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [BW-1:0] got,
                         input logic [BW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        p1   = {4{32'hA5A5_0001}};
        p2   = {4{32'h5A5A_0002}};
        wblk = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};

        reset          = 1'b1;
        ic_mem_address = '0;
        ic_mem_valid   = 1'b0;
        dc_mem_address = '0;
        dc_mem_valid   = 1'b0;
        dc_mem_rw      = 1'b0;
        dc_mem_wdata   = '0;
        dram_rdata     = '0;
        dram_ready     = 1'b0;

        nxt();
        nxt();
        check("rst_dv", dram_valid, 0);
        check("rst_ir", ic_mem_ready, 0);
        check("rst_dr", dc_mem_ready, 0);
        check("rst_addr", dram_address, 0);
        check("rst_rw", dram_rw, 0);
        reset = 1'b0;

        // single icache read, DRAM answers in cycle 5
        base_dv = dv_cnt;
        nxt();
        ic_mem_valid   = 1'b1;
        ic_mem_address = 32'h100;
        #1 check("a0_dv", dram_valid, 0);
        nxt();
        ic_mem_valid = 1'b0;
        #1 check("a1_dv", dram_valid, 0);
        nxt();
        #1 check("a2_dv", dram_valid, 1);
        check("a2_addr", dram_address, 32'h100);
        check("a2_rw", dram_rw, 0);
        nxt();
        #1 check("a3_dv", dram_valid, 0);
        check("a3_addr", dram_address, 32'h100);
        nxt();
        #1 check("a4_ir", ic_mem_ready, 0);
        nxt();
        dram_ready = 1'b1;
        dram_rdata = p1;
        #1 check("a5_ir", ic_mem_ready, 1);
        check("a5_idata", ic_mem_data, p1);
        check("a5_dr", dc_mem_ready, 0);
        check("a5_ddata", dc_mem_data, p1);
        nxt();
        dram_ready = 1'b0;
        #1 check("a6_ir", ic_mem_ready, 0);
        check("a6_addr", dram_address, 0);
        check("a_dv_cnt", dv_cnt - base_dv, 1);

        // simultaneous pair, then a second pair formed at dc ready
        nxt();
        ic_mem_valid   = 1'b1;
        ic_mem_address = 32'h300;
        dc_mem_valid   = 1'b1;
        dc_mem_rw      = 1'b1;
        dc_mem_address = 32'h200;
        dc_mem_wdata   = wblk;
        nxt();
        ic_mem_valid = 1'b0;
        dc_mem_valid = 1'b0;
        #1 check("b1_dv", dram_valid, 0);
        nxt();
        #1 check("b2_dv", dram_valid, 1);
        check("b2_addr", dram_address, 32'h200);
        check("b2_rw", dram_rw, 1);
        check("b2_wdata", dram_wdata, wblk);
        nxt();
        dram_ready     = 1'b1;
        dram_rdata     = p2;
        dc_mem_valid   = 1'b1;
        dc_mem_rw      = 1'b0;
        dc_mem_address = 32'h240;
        dc_mem_wdata   = '0;
        ic_mem_valid   = 1'b1;
        ic_mem_address = 32'h340;
        #1 check("b3_dr", dc_mem_ready, 1);
        check("b3_ir", ic_mem_ready, 0);
        check("b3_rw", dram_rw, 1);
        nxt();
        dram_ready   = 1'b0;
        dc_mem_valid = 1'b0;
        ic_mem_valid = 1'b0;
        #1 check("b4_dv", dram_valid, 0);
        nxt();
        #1 check("b5_dv", dram_valid, 1);
        check("b5_rw", dram_rw, 0);
`ifdef ARB_ROUND_ROBIN_EN
        check("b5_addr", dram_address, 32'h300);
`else
        check("b5_addr", dram_address, 32'h240);
`endif
        nxt();
        dram_ready = 1'b1;
        dram_rdata = p1;
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        check("b6_ir", ic_mem_ready, 1);
        check("b6_dr", dc_mem_ready, 0);
`else
        check("b6_dr", dc_mem_ready, 1);
        check("b6_ir", ic_mem_ready, 0);
`endif
        nxt();
        dram_ready = 1'b0;
        #1 check("b7_dv", dram_valid, 0);
        nxt();
        #1 check("b8_dv", dram_valid, 1);
`ifdef ARB_ROUND_ROBIN_EN
        check("b8_addr", dram_address, 32'h240);
`else
        check("b8_addr", dram_address, 32'h300);
`endif
        nxt();
        dram_ready = 1'b1;
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        check("b9_dr", dc_mem_ready, 1);
        check("b9_ir", ic_mem_ready, 0);
`else
        check("b9_ir", ic_mem_ready, 1);
        check("b9_dr", dc_mem_ready, 0);
`endif
        nxt();
        dram_ready = 1'b0;
        #1 check("b10_dv", dram_valid, 0);

        // repeated icache valid while its request is in service
        base_dv = dv_cnt;
        nxt();
        ic_mem_valid   = 1'b1;
        ic_mem_address = 32'h400;
        nxt();
        ic_mem_valid = 1'b0;
        nxt();
        ic_mem_valid   = 1'b1;
        ic_mem_address = 32'h480;
        #1 check("c2_dv", dram_valid, 1);
        nxt();
        #1 check("c3_addr", dram_address, 32'h400);
        nxt();
        ic_mem_valid = 1'b0;
        dram_ready   = 1'b1;
        #1 check("c4_ir", ic_mem_ready, 1);
        nxt();
        dram_ready = 1'b0;
        nxt();
        nxt();
        nxt();
        #1 check("c_dv_cnt", dv_cnt - base_dv, 1);

        // reset during a dcache write-back
        nxt();
        dc_mem_valid   = 1'b1;
        dc_mem_rw      = 1'b1;
        dc_mem_address = 32'h500;
        dc_mem_wdata   = wblk;
        nxt();
        dc_mem_valid = 1'b0;
        nxt();
        #1 check("d2_dv", dram_valid, 1);
        check("d2_addr", dram_address, 32'h500);
        base_dr = dr_cnt;
        reset      = 1'b1;
        dram_ready = 1'b1;
        #1 check("d2_rst_dv", dram_valid, 0);
        check("d2_rst_addr", dram_address, 0);
        check("d2_rst_rw", dram_rw, 0);
        check("d2_rst_dr", dc_mem_ready, 0);
        base_dv = dv_cnt;
        nxt();
        nxt();
        reset = 1'b0;
        #1 check("d_idle_dr", dc_mem_ready, 0);
        nxt();
        dram_ready = 1'b0;
        nxt();
        nxt();
        nxt();
        #1 check("d_dr_cnt", dr_cnt - base_dr, 0);
        check("d_dv_cnt", dv_cnt - base_dv, 0);

        check("both_ready", both_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
